// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// KEYPAD_SIM_FAST_SCAN_EN selects a 4-clock column period for fast simulation.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    FR_NONE   = 2'd0,
    FR_SINGLE = 2'd1,
    FR_MULTI  = 2'd2
  } frame_class_t;

  localparam logic [3:0] COL_PAT_0 = 4'b1110;
  localparam logic [3:0] COL_PAT_1 = 4'b1101;
  localparam logic [3:0] COL_PAT_2 = 4'b1011;
  localparam logic [3:0] COL_PAT_3 = 4'b0111;

  localparam int SCAN_PERIOD_FAST  = 4;
  localparam int SCAN_PERIOD_BOARD = 32768;

`ifdef KEYPAD_SIM_FAST_SCAN_EN
  localparam int SCAN_PERIOD = SCAN_PERIOD_FAST;
`else
  localparam int SCAN_PERIOD = SCAN_PERIOD_BOARD;
`endif

  function automatic logic [3:0] col_pattern(input logic [1:0] idx);
    logic [3:0] pat;
    case (idx)
      2'd0:    pat = COL_PAT_0;
      2'd1:    pat = COL_PAT_1;
      2'd2:    pat = COL_PAT_2;
      default: pat = COL_PAT_3;
    endcase
    return pat;
  endfunction

  // lows holds one bit per key at index {row_idx, col_idx}.
  function automatic frame_class_t classify_frame(input logic [15:0] lows);
    int n;
    frame_class_t cls;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      if (lows[i]) n++;
    end
    if (n == 0)      cls = FR_NONE;
    else if (n == 1) cls = FR_SINGLE;
    else             cls = FR_MULTI;
    return cls;
  endfunction

  function automatic logic [3:0] lowest_key(input logic [15:0] lows);
    logic [3:0] code;
    logic       found;
    code  = 4'h0;
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (lows[i] && !found) begin
        code  = 4'(i);
        found = 1'b1;
      end
    end
    return code;
  endfunction

  function automatic logic [2:0] sat_inc3(input logic [2:0] c);
    return (c == 3'd7) ? 3'd7 : c + 3'd1;
  endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the active-low keypad rows; resets to "no row low".
module keypad_row_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          meta_reg[gi] <= 1'b1;
          sync_reg[gi] <= 1'b1;
        end else begin
          meta_reg[gi] <= d[gi];
          sync_reg[gi] <= meta_reg[gi];
        end
      end
    end
  endgenerate

  assign q = sync_reg;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with frame-based press/release debouncing.
// Column period comes from keypad_pkg (see KEYPAD_SIM_FAST_SCAN_EN) unless overridden.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES  = 4,
  parameter int SCAN_PERIOD_CLKS = SCAN_PERIOD
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int SCAN_W = (SCAN_PERIOD_CLKS > 1) ? $clog2(SCAN_PERIOD_CLKS) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_PERIOD_CLKS - 1);
  localparam logic [2:0] DB_TARGET = 3'(DEBOUNCE_FRAMES);

  logic [3:0]        row_sync;
  logic [SCAN_W-1:0] scan_cnt_reg;
  logic [1:0]        col_idx_reg;
  logic [15:0]       frame_lows_reg;
  logic [15:0]       lows_next;
  logic              frame_done_reg;
  frame_class_t      frame_class_reg;
  logic [3:0]        frame_code_reg;
  logic              sample_en;

  state_t            state_reg, state_next;
  logic [2:0]        count_reg, count_next;
  logic [3:0]        cand_reg, cand_next;
  logic [3:0]        key_code_reg;
  logic              key_valid_reg;
  logic              accept;
  logic [2:0]        count_inc;

  keypad_row_sync #(.WIDTH(4)) u_row_sync (
    .clock (clock),
    .reset (reset),
    .d     (row_in),
    .q     (row_sync)
  );

  // Rows are only trusted on the last clock of a column period, after settling.
  assign sample_en = (scan_cnt_reg == SCAN_LAST);

  always_comb begin
    lows_next = frame_lows_reg;
    for (int r = 0; r < 4; r++) begin
      if (!row_sync[r]) lows_next[{2'(r), col_idx_reg}] = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scan_cnt_reg    <= '0;
      col_idx_reg     <= 2'd0;
      frame_lows_reg  <= 16'h0;
      frame_done_reg  <= 1'b0;
      frame_class_reg <= FR_NONE;
      frame_code_reg  <= 4'h0;
    end else begin
      frame_done_reg <= 1'b0;
      if (sample_en) begin
        scan_cnt_reg <= '0;
        col_idx_reg  <= col_idx_reg + 2'd1;
        if (col_idx_reg == 2'd3) begin
          frame_lows_reg  <= 16'h0;
          frame_done_reg  <= 1'b1;
          frame_class_reg <= classify_frame(lows_next);
          frame_code_reg  <= lowest_key(lows_next);
        end else begin
          frame_lows_reg <= lows_next;
        end
      end else begin
        scan_cnt_reg <= scan_cnt_reg + 1'b1;
      end
    end
  end

  assign col_out = col_pattern(col_idx_reg);

  // FSM state register, with the accepted-key registers it owns.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      count_reg     <= 3'd0;
      cand_reg      <= 4'h0;
      key_code_reg  <= 4'h0;
      key_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      cand_reg      <= cand_next;
      key_valid_reg <= accept;
      if (accept) key_code_reg <= cand_next;
    end
  end

  assign count_inc = sat_inc3(count_reg);

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    cand_next  = cand_reg;
    accept     = 1'b0;
    if (frame_done_reg) begin
      case (state_reg)
        ST_IDLE: begin
          if (frame_class_reg == FR_SINGLE) begin
            cand_next = frame_code_reg;
            if (DB_TARGET <= 3'd1) begin
              state_next = ST_PRESSED;
              count_next = 3'd0;
              accept     = 1'b1;
            end else begin
              state_next = ST_DEBOUNCE;
              count_next = 3'd1;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (frame_class_reg == FR_SINGLE && frame_code_reg == cand_reg) begin
            if (count_inc >= DB_TARGET) begin
              state_next = ST_PRESSED;
              count_next = 3'd0;
              accept     = 1'b1;
            end else begin
              count_next = count_inc;
            end
          end else begin
            state_next = ST_IDLE;
            count_next = 3'd0;
          end
        end
        ST_PRESSED: begin
          if (frame_class_reg == FR_NONE) begin
            if (DB_TARGET <= 3'd1) begin
              state_next = ST_IDLE;
              count_next = 3'd0;
            end else begin
              state_next = ST_RELEASE;
              count_next = 3'd1;
            end
          end
        end
        default: begin
          if (frame_class_reg == FR_NONE) begin
            if (count_inc >= DB_TARGET) begin
              state_next = ST_IDLE;
              count_next = 3'd0;
            end else begin
              count_next = count_inc;
            end
          end else begin
            state_next = ST_PRESSED;
            count_next = 3'd0;
          end
        end
      endcase
    end
  end

  always_comb begin
    key_down  = (state_reg == ST_PRESSED) || (state_reg == ST_RELEASE);
    key_valid = key_valid_reg;
    key_code  = key_code_reg;
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed table-driven bench for keypad_scanner with a 4-clock column period.
module tb_keypad_scanner;

  logic       clock;
  logic       reset;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  logic [15:0] key_mask;
  int          tests_run;
  int          tests_failed;

  keypad_scanner #(
    .DEBOUNCE_FRAMES  (4),
    .SCAN_PERIOD_CLKS (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Physical keypad model: key {r,c} pulls row r low while column c is strobed.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (key_mask[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
      end
    end
  end

  typedef struct {
    logic [15:0] mask;
    int          frames;
    int          exp_valid;
    logic        exp_down;
    logic [3:0]  exp_code;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [15:0] m, input int f, input int v,
                              input logic d, input logic [3:0] c);
    vec_t x;
    x.mask = m; x.frames = f; x.exp_valid = v; x.exp_down = d; x.exp_code = c;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs n frames from an aligned negedge; returns valid pulses and column errors.
  task automatic run_frames(input logic [15:0] m, input int n,
                            output int valids, output int col_errs);
    int pos;
    logic [3:0] exp_col;
    key_mask = m;
    valids   = 0;
    col_errs = 0;
    for (int i = 1; i <= 16 * n; i++) begin
      @(negedge clock);
      if (key_valid) valids++;
      pos     = (1 + i) % 16;
      exp_col = ~(4'b0001 << (pos / 4));
      if (col_out !== exp_col) col_errs++;
    end
  endtask

  task automatic apply_vec(input int idx, input vec_t v);
    int valids, col_errs;
    run_frames(v.mask, v.frames, valids, col_errs);
    $display("[TB] vec %0d mask=%04h frames=%0d valid=%0d down=%0b code=%0h",
             idx, v.mask, v.frames, valids, key_down, key_code);
    check($sformatf("v%0d valid_count", idx), valids, v.exp_valid);
    check($sformatf("v%0d key_down", idx), {31'd0, key_down}, {31'd0, v.exp_down});
    check($sformatf("v%0d key_code", idx), {28'd0, key_code}, {28'd0, v.exp_code});
    check($sformatf("v%0d col_scan", idx), col_errs, 0);
  endtask

  task automatic release_reset_aligned();
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    key_mask     = 16'h0;
    reset        = 1'b1;

    // Idle scan, accept of key 9, release, aborted press, MULTI, extra key, release bounce.
    vecs.push_back(mk(16'h0000, 4, 0, 1'b0, 4'h0));
    vecs.push_back(mk(16'h0200, 4, 1, 1'b1, 4'h9));
    vecs.push_back(mk(16'h0000, 3, 0, 1'b1, 4'h9));
    vecs.push_back(mk(16'h0000, 1, 0, 1'b0, 4'h9));
    vecs.push_back(mk(16'h0200, 3, 0, 1'b0, 4'h9));
    vecs.push_back(mk(16'h0000, 1, 0, 1'b0, 4'h9));
    vecs.push_back(mk(16'h0044, 8, 0, 1'b0, 4'h9));
    vecs.push_back(mk(16'h0000, 1, 0, 1'b0, 4'h9));
    vecs.push_back(mk(16'h0001, 4, 1, 1'b1, 4'h0));
    vecs.push_back(mk(16'h0021, 4, 0, 1'b1, 4'h0));
    vecs.push_back(mk(16'h0000, 4, 0, 1'b0, 4'h0));
    vecs.push_back(mk(16'h0008, 4, 1, 1'b1, 4'h3));
    vecs.push_back(mk(16'h0000, 2, 0, 1'b1, 4'h3));
    vecs.push_back(mk(16'h0008, 1, 0, 1'b1, 4'h3));
    vecs.push_back(mk(16'h0000, 3, 0, 1'b1, 4'h3));
    vecs.push_back(mk(16'h0000, 1, 0, 1'b0, 4'h3));
    vecs.push_back(mk(16'h1000, 3, 0, 1'b0, 4'h3));

    repeat (3) @(negedge clock);
    #1;
    check("reset col_out", {28'd0, col_out}, 32'hE);
    check("reset key_code", {28'd0, key_code}, 32'h0);
    check("reset key_valid", {31'd0, key_valid}, 32'h0);
    check("reset key_down", {31'd0, key_down}, 32'h0);
    release_reset_aligned();

    foreach (vecs[i]) apply_vec(i, vecs[i]);

    // Reset in the middle of debouncing key C: outputs clear at once.
    begin
      int valids, col_errs;
      int rst_valids;
      @(negedge clock);
      reset = 1'b1;
      #1;
      $display("[TB] mid-debounce reset: col=%b code=%0h valid=%0b down=%0b",
               col_out, key_code, key_valid, key_down);
      check("midrst col_out", {28'd0, col_out}, 32'hE);
      check("midrst key_code", {28'd0, key_code}, 32'h0);
      check("midrst key_down", {31'd0, key_down}, 32'h0);
      rst_valids = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clock);
        if (key_valid) rst_valids++;
      end
      check("midrst no_valid", rst_valids, 0);
      release_reset_aligned();
      $display("[TB] after reset release: col=%b", col_out);
      check("post-reset col_out", {28'd0, col_out}, 32'hE);
      run_frames(16'h1000, 3, valids, col_errs);
      $display("[TB] key C 3 frames after reset: valid=%0d code=%0h", valids, key_code);
      check("post-reset 3fr valid", valids, 0);
      check("post-reset scan", col_errs, 0);
      run_frames(16'h1000, 1, valids, col_errs);
      $display("[TB] key C 4th frame: valid=%0d code=%0h down=%0b", valids, key_code, key_down);
      check("post-reset 4fr valid", valids, 1);
      check("post-reset key_code", {28'd0, key_code}, 32'hC);
      check("post-reset key_down", {31'd0, key_down}, 32'h1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
